// File: rtl/sram_access_monitor.sv
// sram_access_monitor
// Watches one single-port SRAM channel and flags three kinds of misuse:
// write enable without chip select, accesses beyond the legal address
// range, and read data that disagrees with the last value written.
// Written values are remembered in a small direct-mapped shadow store.
// Reads that miss the shadow are never treated as errors.
// Errors show as one-cycle pulses, sticky flags, a saturating count and a
// capture of the first error (its kind and its address).
// RD_LAT must lie in 1..4 and SHADOW_DEPTH must be a power of two >= 2.

module sram_access_monitor #(
  parameter int          ADDR_W       = 16,
  parameter int          DATA_W       = 8,
  parameter int unsigned ADDR_LIMIT   = 'h1000,
  parameter int          RD_LAT       = 1,
  parameter int          SHADOW_DEPTH = 16,
  parameter int          CNT_W        = 16
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_check_enable,
  input  logic              i_clear,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_err_enable,
  output logic              o_err_addr,
  output logic              o_err_data,
  output logic [2:0]        o_err_sticky,
  output logic [CNT_W-1:0]  o_err_count,
  output logic              o_first_valid,
  output logic [1:0]        o_first_code,
  output logic [ADDR_W-1:0] o_first_addr
);

  localparam int IDX_W = $clog2(SHADOW_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W;
  // One extra bit so that a limit of exactly 2^ADDR_W still compares correctly
  localparam logic [ADDR_W:0]  LIMIT_EXT = (ADDR_W+1)'(ADDR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] CODE_ENABLE = 2'b01;
  localparam logic [1:0] CODE_ADDR   = 2'b10;
  localparam logic [1:0] CODE_DATA   = 2'b11;

  // Request decode
  logic             inRange;
  logic             wrReq;
  logic             rdReq;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign inRange = ({1'b0, i_addr} < LIMIT_EXT);
  assign wrReq   = i_cs & i_we & inRange;
  assign rdReq   = i_cs & ~i_we & inRange;
  assign idx     = i_addr[IDX_W-1:0];
  assign tag     = i_addr[ADDR_W-1:IDX_W];

  // Shadow store: only the valid bits need a reset, tag and data follow them
  logic [SHADOW_DEPTH-1:0] shValid_q;
  logic [TAG_W-1:0]        shTag_q  [SHADOW_DEPTH];
  logic [DATA_W-1:0]       shData_q [SHADOW_DEPTH];

  logic              lookupHit;
  logic [DATA_W-1:0] lookupData;

  assign lookupHit  = shValid_q[idx] & (shTag_q[idx] == tag);
  assign lookupData = shData_q[idx];

  // Mark a shadow entry valid on every in-range write; reset forgets everything
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      shValid_q <= '0;
    end else if (wrReq) begin
      shValid_q[idx] <= 1'b1;
    end
  end

  // Store tag and data of in-range writes (payload, no reset needed)
  always_ff @(posedge i_CLK) begin
    if (wrReq) begin
      shTag_q[idx]  <= tag;
      shData_q[idx] <= i_din;
    end
  end

  // Read pipeline: lookup result travels RD_LAT stages to meet i_dout
  logic [RD_LAT-1:0] pValid_q;
  logic [RD_LAT-1:0] pHit_q;
  logic [ADDR_W-1:0] pAddr_q [RD_LAT];
  logic [DATA_W-1:0] pExp_q  [RD_LAT];

  // Control bits of the pipeline, emptied by reset so in-flight reads vanish
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      pValid_q <= '0;
      pHit_q   <= '0;
    end else begin
      pValid_q[0] <= rdReq;
      pHit_q[0]   <= lookupHit;
      for (int i = 1; i < RD_LAT; i++) begin
        pValid_q[i] <= pValid_q[i-1];
        pHit_q[i]   <= pHit_q[i-1];
      end
    end
  end

  // Payload of the pipeline, only meaningful while the matching valid bit is set
  always_ff @(posedge i_CLK) begin
    pAddr_q[0] <= i_addr;
    pExp_q[0]  <= lookupData;
    for (int i = 1; i < RD_LAT; i++) begin
      pAddr_q[i] <= pAddr_q[i-1];
      pExp_q[i]  <= pExp_q[i-1];
    end
  end

  // Error detection for this cycle
  logic enDet;
  logic addrDet;
  logic dataDet;

  assign enDet   = i_check_enable & i_we & ~i_cs;
  assign addrDet = i_check_enable & i_cs & ~inRange;
  assign dataDet = i_check_enable & pValid_q[RD_LAT-1] & pHit_q[RD_LAT-1]
                 & (i_dout != pExp_q[RD_LAT-1]);

  // Status registers
  logic              errEnable_q, errAddr_q, errData_q;
  logic [2:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              firstValid_q, firstValid_d;
  logic [1:0]        firstCode_q, firstCode_d;
  logic [ADDR_W-1:0] firstAddr_q, firstAddr_d;

  logic [1:0]       errNum;
  logic [CNT_W+1:0] cntSum;

  // Next status: clear wipes the old state first, then this cycle's errors are recorded
  always_comb begin
    sticky_d     = i_clear ? 3'b000 : sticky_q;
    count_d      = i_clear ? '0 : count_q;
    firstValid_d = i_clear ? 1'b0 : firstValid_q;
    firstCode_d  = i_clear ? 2'b00 : firstCode_q;
    firstAddr_d  = i_clear ? '0 : firstAddr_q;
    errNum       = {1'b0, enDet} + {1'b0, addrDet} + {1'b0, dataDet};
    cntSum       = (CNT_W+2)'(count_d) + (CNT_W+2)'(errNum);

    sticky_d = sticky_d | {dataDet, addrDet, enDet};
    count_d  = (cntSum > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX : cntSum[CNT_W-1:0];

    if (!firstValid_d && (errNum != 2'd0)) begin
      firstValid_d = 1'b1;
      if (dataDet) begin
        firstCode_d = CODE_DATA;
        firstAddr_d = pAddr_q[RD_LAT-1];
      end else if (addrDet) begin
        firstCode_d = CODE_ADDR;
        firstAddr_d = i_addr;
      end else begin
        firstCode_d = CODE_ENABLE;
        firstAddr_d = i_addr;
      end
    end
  end

  // Register pulses and status so every error appears one cycle after detection
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      errEnable_q  <= 1'b0;
      errAddr_q    <= 1'b0;
      errData_q    <= 1'b0;
      sticky_q     <= 3'b000;
      count_q      <= '0;
      firstValid_q <= 1'b0;
      firstCode_q  <= 2'b00;
      firstAddr_q  <= '0;
    end else begin
      errEnable_q  <= enDet;
      errAddr_q    <= addrDet;
      errData_q    <= dataDet;
      sticky_q     <= sticky_d;
      count_q      <= count_d;
      firstValid_q <= firstValid_d;
      firstCode_q  <= firstCode_d;
      firstAddr_q  <= firstAddr_d;
    end
  end

  assign o_err_enable  = errEnable_q;
  assign o_err_addr    = errAddr_q;
  assign o_err_data    = errData_q;
  assign o_err_sticky  = sticky_q;
  assign o_err_count   = count_q;
  assign o_first_valid = firstValid_q;
  assign o_first_code  = firstCode_q;
  assign o_first_addr  = firstAddr_q;

endmodule

// File: tb/tb_sram_access_monitor.sv
// tb_sram_access_monitor
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a transaction-level reference model (write history + read queue).

module tb_sram_access_monitor;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 8;
  localparam int ADDR_LIMIT   = 'h1000;
  localparam int RD_LAT       = 2;
  localparam int SHADOW_DEPTH = 16;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int IDX_BITS     = 4;

  logic              clk;
  logic              rstN;
  logic              checkEnable;
  logic              clear;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              errEnable;
  logic              errAddr;
  logic              errData;
  logic [2:0]        errSticky;
  logic [CNT_W-1:0]  errCount;
  logic              firstValid;
  logic [1:0]        firstCode;
  logic [ADDR_W-1:0] firstAddr;

  int vectors     = 0;
  int miscompares = 0;

  sram_access_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LIMIT(ADDR_LIMIT),
    .RD_LAT(RD_LAT), .SHADOW_DEPTH(SHADOW_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_CLK(clk), .i_RST(rstN), .i_check_enable(checkEnable), .i_clear(clear),
    .i_cs(cs), .i_we(we), .i_addr(addr), .i_din(din), .i_dout(dout),
    .o_err_enable(errEnable), .o_err_addr(errAddr), .o_err_data(errData),
    .o_err_sticky(errSticky), .o_err_count(errCount), .o_first_valid(firstValid),
    .o_first_code(firstCode), .o_first_addr(firstAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct { int due; logic [15:0] addr; logic [7:0] exp; bit hit; } rd_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
  rd_t pend[$];
  wr_t hist[$];
  int          cyc = 0;
  bit          mEn, mAd, mDa;
  logic [2:0]  mSticky;
  int          mCount;
  bit          mFirstValid;
  logic [1:0]  mFirstCode;
  logic [15:0] mFirstAddr;

  // Everything forgotten at reset: history, reads in flight, status
  function automatic void modelReset();
    pend.delete();
    hist.delete();
    mEn = 0; mAd = 0; mDa = 0;
    mSticky = 3'b000; mCount = 0;
    mFirstValid = 0; mFirstCode = 2'b00; mFirstAddr = 16'h0000;
  endfunction

  // A read hits if the latest write sharing its shadow slot went to this very address
  function automatic void lookup(input logic [15:0] a, output bit hit, output logic [7:0] d);
    hit = 0;
    d   = 8'h00;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].addr[IDX_BITS-1:0] == a[IDX_BITS-1:0]) begin
        hit = (hist[i].addr == a);
        d   = hist[i].data;
        break;
      end
    end
  endfunction

  // Advance the model by one clock cycle with the inputs that were applied
  function automatic void modelStep(input bit c, input bit w, input logic [15:0] a,
                                    input logic [7:0] di, input logic [7:0] dO,
                                    input bit en, input bit clr);
    bit          inR;
    bit          h;
    logic [7:0]  d;
    logic [15:0] daAddr;
    int          n;
    cyc++;
    inR    = (int'(a) < ADDR_LIMIT);
    mEn    = en && w && !c;
    mAd    = en && c && !inR;
    mDa    = 0;
    daAddr = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mDa    = en && pend[0].hit && (dO !== pend[0].exp);
      daAddr = pend[0].addr;
      pend.delete(0);
    end
    if (c && !w && inR) begin
      lookup(a, h, d);
      pend.push_back('{cyc + RD_LAT, a, d, h});
    end
    if (c && w && inR) hist.push_back('{a, di});
    if (clr) begin
      mSticky = 3'b000; mCount = 0;
      mFirstValid = 0; mFirstCode = 2'b00; mFirstAddr = 16'h0000;
    end
    mSticky = mSticky | {mDa, mAd, mEn};
    n = int'(mDa) + int'(mAd) + int'(mEn);
    mCount = (mCount + n > CNT_MAX) ? CNT_MAX : mCount + n;
    if (!mFirstValid && n > 0) begin
      mFirstValid = 1;
      if (mDa)      begin mFirstCode = 2'b11; mFirstAddr = daAddr; end
      else if (mAd) begin mFirstCode = 2'b10; mFirstAddr = a;      end
      else          begin mFirstCode = 2'b01; mFirstAddr = a;      end
    end
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    expectEq("err_enable",  32'(errEnable),  32'(mEn));
    expectEq("err_addr",    32'(errAddr),    32'(mAd));
    expectEq("err_data",    32'(errData),    32'(mDa));
    expectEq("err_sticky",  32'(errSticky),  32'(mSticky));
    expectEq("err_count",   32'(errCount),   32'(mCount));
    expectEq("first_valid", 32'(firstValid), 32'(mFirstValid));
    expectEq("first_code",  32'(firstCode),  32'(mFirstCode));
    expectEq("first_addr",  32'(firstAddr),  32'(mFirstAddr));
  endtask

  // Drive one cycle of inputs, let the edge pass, then check against the model
  task automatic applyStimulus(input bit c, input bit w, input logic [15:0] a,
                               input logic [7:0] di, input logic [7:0] dO,
                               input bit en, input bit clr);
    cs = c; we = w; addr = a; din = di; dout = dO; checkEnable = en; clear = clr;
    @(posedge clk);
    #1;
    modelStep(c, w, a, di, dO, en, clr);
    checkOutput();
  endtask

  task automatic idle(input logic [7:0] dO);
    applyStimulus(0, 0, 16'h0000, 8'h00, dO, 1, 0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    int          r;

    rstN = 1'b0;
    cs = 0; we = 0; addr = '0; din = '0; dout = '0; checkEnable = 1; clear = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] write then read back with matching data");
    applyStimulus(1, 1, 16'h0010, 8'h3A, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0010, 8'h00, 8'h00, 1, 0);
    idle(8'h00);
    idle(8'h3A);
    expectEq("t1_count", 32'(errCount), 32'd0);

    $display("[TB] write enable without chip select");
    applyStimulus(0, 1, 16'h0005, 8'h00, 8'h00, 1, 0);
    expectEq("t2_pulse",  32'(errEnable), 32'd1);
    expectEq("t2_sticky", 32'(errSticky), 32'b001);
    expectEq("t2_code",   32'(firstCode), 32'b01);
    expectEq("t2_count",  32'(errCount),  32'd1);
    idle(8'h00);
    expectEq("t2_pulse_end", 32'(errEnable), 32'd0);
    applyStimulus(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1);

    $display("[TB] out-of-range accesses");
    applyStimulus(1, 0, 16'h1000, 8'h00, 8'h00, 1, 0);
    expectEq("t3_pulse", 32'(errAddr),   32'd1);
    expectEq("t3_addr",  32'(firstAddr), 32'h1000);
    applyStimulus(1, 1, 16'h0000, 8'h12, 8'h00, 1, 0);
    applyStimulus(1, 1, 16'h1000, 8'h77, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0000, 8'h00, 8'h00, 1, 0);
    idle(8'h00);
    idle(8'h99);
    expectEq("t3_shadow_kept", 32'(errData), 32'd1);

    $display("[TB] data mismatch and never-written read");
    applyStimulus(1, 1, 16'h0020, 8'h55, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0020, 8'h00, 8'h00, 1, 0);
    idle(8'h00);
    idle(8'h54);
    expectEq("t4_data_pulse", 32'(errData), 32'd1);
    applyStimulus(1, 0, 16'h0030, 8'h00, 8'h00, 1, 0);
    idle(8'h00);
    idle(8'hC3);
    expectEq("t4_miss", 32'(errData), 32'd0);

    $display("[TB] tag alias");
    applyStimulus(1, 1, 16'h0011, 8'hA1, 8'h00, 1, 0);
    applyStimulus(1, 1, 16'h0021, 8'hB2, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0011, 8'h00, 8'h00, 1, 0);
    idle(8'h00);
    idle(8'h5E);
    expectEq("t5_alias", 32'(errData), 32'd0);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < CNT_MAX + 4; i++) applyStimulus(0, 1, 16'h0001, 8'h00, 8'h00, 1, 0);
    expectEq("t6_sat", 32'(errCount), 32'(CNT_MAX));
    applyStimulus(1, 0, 16'h2000, 8'h00, 8'h00, 1, 1);
    expectEq("t6_clr_count",  32'(errCount),  32'd1);
    expectEq("t6_clr_sticky", 32'(errSticky), 32'b010);
    expectEq("t6_clr_addr",   32'(firstAddr), 32'h2000);

    $display("[TB] reset during a read");
    applyStimulus(1, 1, 16'h0040, 8'h11, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0040, 8'h00, 8'h00, 1, 0);
    cs = 0; we = 0; dout = 8'hEE;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) idle(8'hEE);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = 16'h0FF8 + 16'($urandom_range(0, 15));
      else if (r == 1) ra = 16'($urandom);
      else             ra = 16'($urandom_range(0, 63));
      if (pend.size() > 0 && pend[0].due == cyc + 1)
        rd = ($urandom_range(0, 3) == 0) ? (pend[0].exp ^ 8'($urandom_range(1, 255))) : pend[0].exp;
      else
        rd = 8'($urandom);
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, ra,
                    8'($urandom), rd, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
